// File: rtl/snn_sched_ctrl.sv
// Control FSM of the SNN engine: steers the input burst into the operand buffers,
// issues the conv/pool/fc/post/dist command stream and frames the result with out_valid.
module snn_sched_ctrl #(
  parameter int N_IMG  = 2,
  parameter int N_CH   = 3,
  parameter int IMG_W  = 4,
  parameter int OUTS_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [1:0] Opt,
  output logic [1:0] opt_q,
  output logic       buf_we,
  output logic [1:0] buf_sel,
  output logic [6:0] buf_addr,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [2:0] cmd_op,
  output logic       cmd_img,
  output logic [1:0] cmd_ch,
  output logic [1:0] cmd_row,
  output logic [1:0] cmd_col,
  output logic       cmd_last,
  input  logic       res_valid,
  output logic       out_valid,
  output logic       busy
);

  localparam int IMG_BEATS = N_IMG * N_CH * IMG_W * IMG_W;
  localparam int KER_BEATS = N_CH * 9;
  localparam int ALL_BEATS = IMG_BEATS + KER_BEATS + 4;
  localparam logic [6:0] IMG_END = 7'(IMG_BEATS);
  localparam logic [6:0] KER_END = 7'(IMG_BEATS + KER_BEATS);
  localparam logic [6:0] ALL_END = 7'(ALL_BEATS);

  localparam logic [2:0] OP_CONV = 3'd0;
  localparam logic [2:0] OP_POOL = 3'd1;
  localparam logic [2:0] OP_FC   = 3'd2;
  localparam logic [2:0] OP_POST = 3'd3;
  localparam logic [2:0] OP_DIST = 3'd4;

  localparam logic [1:0] CH_MAX       = 2'(N_CH - 1);
  localparam logic [1:0] CONV_POS_MAX = 2'(IMG_W - 1);
  localparam logic [1:0] POOL_POS_MAX = 2'(IMG_W / 2 - 1);
  localparam logic       IMG_MAX      = 1'(N_IMG - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CONV, S_POOL, S_FC, S_POST, S_DIST, S_OUT
  } state_t;

  state_t            state_q, state_d;
  logic [6:0]        beat_q, beat_d;
  logic [1:0]        opt_d;
  logic              img_q, img_d;
  logic [1:0]        ch_q, ch_d, row_q, row_d, col_q, col_d;
  logic              issued_q, issued_d;
  logic [OUTS_W-1:0] outs_q, outs_d;

  logic       issuing, xfer, dec, last_cmd, phase_done, img_max;
  logic [2:0] op;
  logic [1:0] ch_max, pos_max;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_q   <= '0;
      opt_q    <= '0;
      img_q    <= 1'b0;
      ch_q     <= '0;
      row_q    <= '0;
      col_q    <= '0;
      issued_q <= 1'b0;
      outs_q   <= '0;
    end else begin
      beat_q   <= beat_d;
      opt_q    <= opt_d;
      img_q    <= img_d;
      ch_q     <= ch_d;
      row_q    <= row_d;
      col_q    <= col_d;
      issued_q <= issued_d;
      outs_q   <= outs_d;
    end
  end

  // The LOAD cycle where in_valid is first low already offers CONV command 0.
  always_comb begin
    issuing = 1'b0;
    op      = OP_CONV;
    case (state_q)
      S_LOAD: issuing = !in_valid;
      S_CONV: issuing = 1'b1;
      S_POOL: begin issuing = 1'b1; op = OP_POOL; end
      S_FC:   begin issuing = 1'b1; op = OP_FC;   end
      S_POST: begin issuing = 1'b1; op = OP_POST; end
      S_DIST: begin issuing = 1'b1; op = OP_DIST; end
      default: ;
    endcase
    cmd_valid = issuing && !issued_q && (outs_q != '1);
  end

  assign xfer       = cmd_valid && cmd_ready;
  assign dec        = res_valid && (outs_q != '0);
  assign outs_d     = outs_q + {{(OUTS_W-1){1'b0}}, xfer} - {{(OUTS_W-1){1'b0}}, dec};
  assign phase_done = issued_q && (outs_d == '0);

  assign ch_max   = (op == OP_CONV) ? CH_MAX : 2'd0;
  assign pos_max  = (op == OP_CONV) ? CONV_POS_MAX : (op == OP_DIST) ? 2'd0 : POOL_POS_MAX;
  assign img_max  = (op == OP_DIST) ? 1'b0 : IMG_MAX;
  assign last_cmd = (ch_q == ch_max) && (col_q == pos_max) && (row_q == pos_max) && (img_q == img_max);

  always_comb begin
    beat_d   = beat_q;
    opt_d    = opt_q;
    img_d    = img_q;
    ch_d     = ch_q;
    row_d    = row_q;
    col_d    = col_q;
    issued_d = issued_q;
    if (state_q == S_IDLE) begin
      beat_d = in_valid ? 7'd1 : 7'd0;
      if (in_valid) opt_d = Opt;
    end else if (state_q == S_LOAD && in_valid && beat_q != ALL_END) begin
      beat_d = beat_q + 7'd1;
    end
    if (xfer) begin
      if (last_cmd) begin
        img_d    = 1'b0;
        ch_d     = '0;
        row_d    = '0;
        col_d    = '0;
        issued_d = 1'b1;
      end else if (ch_q != ch_max) begin
        ch_d = ch_q + 2'd1;
      end else begin
        ch_d = '0;
        if (col_q != pos_max) begin
          col_d = col_q + 2'd1;
        end else begin
          col_d = '0;
          if (row_q != pos_max) begin
            row_d = row_q + 2'd1;
          end else begin
            row_d = '0;
            img_d = ~img_q;
          end
        end
      end
    end
    if (phase_done) issued_d = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid)   state_d = S_LOAD;
      S_LOAD: if (!in_valid)  state_d = S_CONV;
      S_CONV: if (phase_done) state_d = S_POOL;
      S_POOL: if (phase_done) state_d = S_FC;
      S_FC:   if (phase_done) state_d = S_POST;
      S_POST: if (phase_done) state_d = S_DIST;
      S_DIST: if (phase_done) state_d = S_OUT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    out_valid = (state_q == S_OUT);
    buf_we    = 1'b0;
    buf_sel   = 2'd0;
    buf_addr  = 7'd0;
    if (state_q == S_IDLE && in_valid) begin
      buf_we = 1'b1;
    end else if (state_q == S_LOAD && in_valid && beat_q != ALL_END) begin
      buf_we = 1'b1;
      if (beat_q < IMG_END) begin
        buf_addr = beat_q;
      end else if (beat_q < KER_END) begin
        buf_sel  = 2'd1;
        buf_addr = beat_q - IMG_END;
      end else begin
        buf_sel  = 2'd2;
        buf_addr = beat_q - KER_END;
      end
    end
    // Fields are zero whenever no command is offered.
    cmd_op   = cmd_valid ? op : 3'd0;
    cmd_img  = cmd_valid && img_q;
    cmd_ch   = cmd_valid ? ch_q : 2'd0;
    cmd_row  = cmd_valid ? row_q : 2'd0;
    cmd_col  = cmd_valid ? col_q : 2'd0;
    cmd_last = cmd_valid && ((op != OP_CONV) || (ch_q == CH_MAX));
  end

endmodule

// File: tb/tb_snn_sched_ctrl.sv
// Directed bench for snn_sched_ctrl: burst load, full command runs with and without
// backpressure, drain/saturation holds and reset from mid-burst and mid-run.
module tb_snn_sched_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, cmd_ready, res_valid;
  logic [1:0] Opt, opt_q, buf_sel, cmd_ch, cmd_row, cmd_col;
  logic       buf_we, cmd_valid, cmd_img, cmd_last, out_valid, busy;
  logic [6:0] buf_addr;
  logic [2:0] cmd_op;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_beat = 0;
  int oc;

  snn_sched_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .Opt(Opt), .opt_q(opt_q),
    .buf_we(buf_we), .buf_sel(buf_sel), .buf_addr(buf_addr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_img(cmd_img),
    .cmd_ch(cmd_ch), .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_last(cmd_last),
    .res_valid(res_valid), .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Packed {op, img, ch, row, col, last} of global command n in issue order.
  function automatic logic [10:0] exp_cmd(input int n);
    int op, i, img, ch, row, col, last;
    if (n < 96) begin
      op = 0; i = n;
      ch = i % 3; col = (i / 3) % 4; row = (i / 12) % 4; img = i / 48;
      last = (ch == 2) ? 1 : 0;
    end else if (n < 120) begin
      op = 1 + (n - 96) / 8; i = (n - 96) % 8;
      ch = 0; col = i % 2; row = (i / 2) % 2; img = i / 4; last = 1;
    end else begin
      op = 4; img = 0; ch = 0; row = 0; col = 0; last = 1;
    end
    return {3'(op), 1'(img), 2'(ch), 2'(row), 2'(col), 1'(last)};
  endfunction

  // Drives nb beats; in_valid is left high so the caller decides when it falls.
  task automatic load(input int nb, input logic [1:0] opt);
    logic [31:0] exp;
    for (int b = 0; b < nb; b++) begin
      in_valid = 1'b1;
      Opt = (b == 0) ? opt : ~opt;
      #1;
      if (b < 96)       exp = {22'd0, 1'b1, 2'd0, 7'(b)};
      else if (b < 123) exp = {22'd0, 1'b1, 2'd1, 7'(b - 96)};
      else if (b < 127) exp = {22'd0, 1'b1, 2'd2, 7'(b - 123)};
      else              exp = 32'd0;
      chk($sformatf("beat%0d", b), {22'd0, buf_we, buf_sel, buf_addr}, exp);
      last_beat = cyc;
      tick();
    end
  endtask

  // hold_mode 1 withholds results at CONV transfer 20 (30 cycles) and after transfer 96 (20 cycles).
  task automatic run(input bit rand_ready, input int stop_n, input int hold_mode, output int out_cyc);
    int n = 0, outs = 0, outc = 0, viol_hold = 0, viol_phase = 0, max_outs = 0;
    int h1_end = 0, h2_end = 0, limit;
    int due[$];
    logic [10:0] cur, held;
    bit stalled = 0, hold, stopped = 0;
    out_cyc = 0;
    limit = cyc + 3000;
    in_valid = 1'b0;
    while (1) begin
      if (cyc >= limit) begin
        chk("timeout_out_pulses", outc, 1);
        break;
      end
      hold = (cyc < h1_end) || (cyc < h2_end);
      cmd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      res_valid = (due.size() > 0) && (due[0] <= cyc) && !hold;
      #1;
      cur = {cmd_op, cmd_img, cmd_ch, cmd_row, cmd_col, cmd_last};
      if (stop_n >= 0 && n == stop_n && cmd_valid) begin
        stopped = 1;
        break;
      end
      if (stalled && (!cmd_valid || cur !== held)) viol_hold++;
      if (cmd_valid && (n == 96 || n == 104 || n == 112 || n == 120) && outs != 0) viol_phase++;
      if (cmd_valid && cmd_ready) begin
        chk($sformatf("cmd%0d", n), cur, exp_cmd(n));
        due.push_back(cyc + 3);
        n++;
        outs++;
        if (hold_mode == 1 && n == 20) h1_end = cyc + 30;
        if (hold_mode == 1 && n == 96) h2_end = cyc + 20;
      end
      if (res_valid) begin
        void'(due.pop_front());
        outs--;
      end
      if (outs > max_outs) max_outs = outs;
      stalled = cmd_valid && !cmd_ready;
      held = cur;
      if (outc > 0 && !out_valid) begin
        chk("busy_after_out", busy, 0);
        break;
      end
      if (out_valid) begin
        outc++;
        out_cyc = cyc;
      end
      tick();
    end
    res_valid = 1'b0;
    if (!stopped) begin
      cmd_ready = 1'b0;
      chk("n_cmds", n, 121);
      chk("out_pulses", outc, 1);
      chk("stall_hold_viol", viol_hold, 0);
      chk("phase_drain_viol", viol_phase, 0);
      if (hold_mode == 1) chk("outs_cap", max_outs, 15);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; Opt = 2'd0; cmd_ready = 1'b0; res_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    // T1: reset from mid-burst
    load(10, 2'b11);
    rst_n = 1'b0; in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_opt_q", opt_q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {buf_we, cmd_valid, out_valid}, 0);
    chk("rst_fields", {buf_sel, buf_addr, cmd_op, cmd_img, cmd_ch, cmd_row, cmd_col, cmd_last}, 0);

    // T2: 128-beat burst, then a plain run
    load(128, 2'b10);
    chk("t2_opt_q", opt_q, 2);
    run(0, -1, 0, oc);
    chk("t2_latency", oc - last_beat, 137);

    // T3: stray results while idle must not underflow
    res_valid = 1'b1; tick(); tick(); res_valid = 1'b0;
    load(127, 2'b01);
    chk("t3_opt_q", opt_q, 1);
    run(0, -1, 0, oc);
    chk("t3_latency", oc - last_beat, 137);

    // T4: random backpressure
    load(127, 2'b00);
    chk("t4_opt_q", opt_q, 0);
    run(1, -1, 0, oc);

    // T5: withheld results: saturation and phase drain
    load(127, 2'b10);
    run(0, -1, 1, oc);

    // T6: reset while CONV command 40 is offered, then a short burst
    load(127, 2'b01);
    run(1, 40, 0, oc);
    rst_n = 1'b0; cmd_ready = 1'b0; res_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_cmd_valid", cmd_valid, 0);
    chk("t6_busy", busy, 0);
    load(5, 2'b11);
    chk("t6_opt_q", opt_q, 3);
    run(0, -1, 0, oc);
    chk("t6_latency", oc - last_beat, 137);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
